// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the imem address and
// registers each fetched word with its PC into a one-entry valid/ready stage.
// Ports: clk, reset (async, active-high), start, halt_req, jump_valid,
//   jump_target[7:0], imem_addr[7:0], imem_instr[7:0], instr_out[7:0],
//   instr_pc[7:0], instr_valid, instr_ready, pc[7:0], running, halted.
// Optional feature: define FETCH_HALT_ON_NOP_EN to halt after a NOP word.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] NOP_WORD = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       halt_req,
  input  logic       jump_valid,
  input  logic [7:0] jump_target,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_instr,
  output logic [7:0] instr_out,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] pc,
  output logic       running,
  output logic       halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_pc;
  logic [7:0] r_out;
  logic [7:0] r_ipc;
  logic       r_valid;
  logic       r_running;
  logic       r_halted;
  logic       w_halt;
  logic       w_load;
  logic       w_jump;
  logic       w_clear;

`ifdef FETCH_HALT_ON_NOP_EN
  // A NOP just loaded acts as a halt request on the next cycle.
  logic r_nop_halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nop_halt <= 1'b0;
    end else begin
      r_nop_halt <= w_load && (imem_instr == NOP_WORD);
    end
  end

  assign w_halt = halt_req || r_nop_halt;
`else
  assign w_halt = halt_req;
`endif

  // State register plus registered state decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == S_RUN);
      r_halted  <= (w_next == S_HALT);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_halt) w_next = S_HALT;
      S_HALT:  if (start && !halt_req) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // Control decode; halt outranks jump, jump outranks load.
  always_comb begin
    w_load  = 1'b0;
    w_jump  = 1'b0;
    w_clear = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (w_halt) begin
          w_clear = r_valid && instr_ready;
        end else if (jump_valid) begin
          // Pending word is flushed even when the decoder takes it.
          w_jump  = 1'b1;
          w_clear = 1'b1;
        end else begin
          w_load = !r_valid || instr_ready;
        end
      end
      default: begin
        w_clear = r_valid && instr_ready;
        w_jump  = jump_valid && !halt_req;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_out   <= NOP_WORD;
      r_ipc   <= 8'h00;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_out   <= imem_instr;
      r_ipc   <= r_pc;
      r_valid <= 1'b1;
      r_pc    <= r_pc + 8'd1;
    end else begin
      if (w_clear) r_valid <= 1'b0;
      if (w_jump) r_pc <= jump_target;
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr_out   = r_out;
  assign instr_pc    = r_ipc;
  assign instr_valid = r_valid;
  assign running     = r_running;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// random control traffic compared against a cycle-level reference model.
module tb_fetch_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       halt_req;
  logic       jump_valid;
  logic [7:0] jump_target;
  logic [7:0] imem_addr;
  logic [7:0] imem_instr;
  logic [7:0] instr_out;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] pc;
  logic       running;
  logic       halted;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  // Reference model state: 0 idle, 1 run, 2 halt.
  int         ms;
  logic [7:0] mpc;
  logic [7:0] mout;
  logic [7:0] mipc;
  logic       mv;
  logic       mnop;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt_req    (halt_req),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .running     (running),
    .halted      (halted)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms   = 0;
    mpc  = 8'h00;
    mout = 8'hF0;
    mipc = 8'h00;
    mv   = 1'b0;
    mnop = 1'b0;
  endtask

  task automatic model_step();
    int   ns;
    logic hx;
    logic loaded;
    ns     = ms;
    loaded = 1'b0;
`ifdef FETCH_HALT_ON_NOP_EN
    hx = halt_req || mnop;
`else
    hx = halt_req;
`endif
    if (ms == 1) begin
      if (hx) begin
        ns = 2;
        if (mv && instr_ready) mv = 1'b0;
      end else if (jump_valid) begin
        mpc = jump_target;
        mv  = 1'b0;
      end else if (!mv || instr_ready) begin
        mout   = mem[mpc];
        mipc   = mpc;
        mv     = 1'b1;
        mpc    = mpc + 8'd1;
        loaded = 1'b1;
      end
    end else begin
      if (mv && instr_ready) mv = 1'b0;
      if (jump_valid && !halt_req) mpc = jump_target;
      if (start && !(ms == 2 && halt_req)) ns = 1;
    end
    mnop = loaded && (mout == 8'hF0);
    ms   = ns;
  endtask

  task automatic check_all();
    chk("pc", pc, mpc);
    chk("imem_addr", imem_addr, mpc);
    chk("instr_valid", {7'd0, instr_valid}, {7'd0, mv});
    chk("instr_out", instr_out, mout);
    chk("instr_pc", instr_pc, mipc);
    chk("running", {7'd0, running}, {7'd0, ms == 1});
    chk("halted", {7'd0, halted}, {7'd0, ms == 2});
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 8'h00);
    chk({tag, "_addr"}, imem_addr, 8'h00);
    chk({tag, "_out"}, instr_out, 8'hF0);
    chk({tag, "_ipc"}, instr_pc, 8'h00);
    chk({tag, "_valid"}, {7'd0, instr_valid}, 8'h00);
    chk({tag, "_running"}, {7'd0, running}, 8'h00);
    chk({tag, "_halted"}, {7'd0, halted}, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom_range(0, 8'hEF));
    end
    mem[0]   = 8'h5A;
    mem[1]   = 8'h5C;
    mem[2]   = 8'h46;
    mem[3]   = 8'h0D;
    mem[7]   = 8'h72;
    mem[8]   = 8'hF0;
    mem[9]   = 8'h31;
    reset       = 1'b1;
    start       = 1'b0;
    halt_req    = 1'b0;
    jump_valid  = 1'b0;
    jump_target = 8'h00;
    instr_ready = 1'b1;
    model_reset();
    #1;
    chk_reset_vals("reset");
    #2;
    reset = 1'b0;

    // Entry address set in IDLE, then start.
    jump_valid  = 1'b1;
    jump_target = 8'h00;
    cyc();
    jump_valid = 1'b0;
    chk("idle_jump_pc", pc, 8'h00);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_running", {7'd0, running}, 8'h01);
    chk("start_novalid", {7'd0, instr_valid}, 8'h00);
    cyc();
    chk("first_out", instr_out, 8'h5A);
    chk("first_ipc", instr_pc, 8'h00);
    chk("first_valid", {7'd0, instr_valid}, 8'h01);
    cyc();
    chk("second_out", instr_out, 8'h5C);
    cyc();
    chk("third_out", instr_out, 8'h46);
    chk("third_ipc", instr_pc, 8'h02);

    // Backpressure for three cycles.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_out", instr_out, 8'h46);
      chk("bp_ipc", instr_pc, 8'h02);
      chk("bp_pc", pc, 8'h03);
    end
    instr_ready = 1'b1;
    cyc();
    chk("bp_rel_out", instr_out, 8'h0D);
    chk("bp_rel_ipc", instr_pc, 8'h03);

    // Jump in RUN: one bubble, then target word.
    jump_valid  = 1'b1;
    jump_target = 8'h07;
    cyc();
    jump_valid = 1'b0;
    chk("jmp_bubble", {7'd0, instr_valid}, 8'h00);
    chk("jmp_pc", pc, 8'h07);
    cyc();
    chk("jmp_out", instr_out, 8'h72);
    chk("jmp_ipc", instr_pc, 8'h07);

    // Jump discarded when coincident with halt.
    jump_valid  = 1'b1;
    jump_target = 8'h40;
    halt_req    = 1'b1;
    cyc();
    jump_valid = 1'b0;
    halt_req   = 1'b0;
    chk("jh_halted", {7'd0, halted}, 8'h01);
    chk("jh_pc", pc, 8'h08);

    // Wrap from FE through 00.
    jump_valid  = 1'b1;
    jump_target = 8'hFE;
    cyc();
    jump_valid = 1'b0;
    chk("wrap_setpc", pc, 8'hFE);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("wrap_fe", instr_pc, 8'hFE);
    cyc();
    chk("wrap_ff", instr_pc, 8'hFF);
    chk("wrap_pc0", pc, 8'h00);
    cyc();
    chk("wrap_00", instr_pc, 8'h00);
    chk("wrap_out", instr_out, 8'h5A);

    // Halt with a pending word under backpressure.
    instr_ready = 1'b0;
    halt_req    = 1'b1;
    cyc();
    halt_req = 1'b0;
    chk("hp_halted", {7'd0, halted}, 8'h01);
    chk("hp_valid", {7'd0, instr_valid}, 8'h01);
    chk("hp_out", instr_out, 8'h5A);
    cyc();
    chk("hp_hold", {7'd0, instr_valid}, 8'h01);
    instr_ready = 1'b1;
    cyc();
    chk("hp_drop", {7'd0, instr_valid}, 8'h00);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("resume_ipc", instr_pc, 8'h01);
    chk("resume_out", instr_out, 8'h5C);

    // NOP word handling.
    jump_valid  = 1'b1;
    jump_target = 8'h08;
    cyc();
    jump_valid = 1'b0;
    cyc();
    chk("nop_out", instr_out, 8'hF0);
    chk("nop_ipc", instr_pc, 8'h08);
    cyc();
`ifdef FETCH_HALT_ON_NOP_EN
    chk("nop_halted", {7'd0, halted}, 8'h01);
    chk("nop_pc", pc, 8'h09);
`else
    chk("nop_stream_out", instr_out, 8'h31);
    chk("nop_stream_run", {7'd0, running}, 8'h01);
`endif

    // Random control traffic.
    for (int i = 0; i < 400; i++) begin
      start       = ($urandom_range(0, 3) == 0);
      halt_req    = ($urandom_range(0, 15) == 0);
      jump_valid  = ($urandom_range(0, 7) == 0);
      jump_target = 8'($urandom);
      instr_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // Reset mid-stream.
    halt_req    = 1'b0;
    jump_valid  = 1'b0;
    instr_ready = 1'b1;
    start       = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    model_reset();
    cyc();
    #2;
    reset = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
